// File: rtl/framebuffer_scanout_if.sv
// ----------------------------------------------------------------------------
// framebuffer_scanout_if
//
// Bundles every non-clock signal of framebuffer_scanout:
//   - framebuffer read port : fb_rd_addr (scanout -> RAM), fb_rd_data (RAM -> scanout)
//   - frame handshake       : display_buf, render_buf, frame_start (scanout -> renderer),
//                             frame_done (renderer -> scanout)
//   - video output          : pixel_out, hsync, vsync, de
//   - status                : missed_frames
//
// Modports:
//   master - the scanout block (drives address, video, handshake outputs)
//   slave  - the environment (framebuffer RAM, video_generator, display)
// ----------------------------------------------------------------------------
interface framebuffer_scanout_if #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 14
);
    logic [ADDR_BITS-1:0] fb_rd_addr;
    logic [DATA_BITS-1:0] fb_rd_data;
    logic                 display_buf;
    logic                 render_buf;
    logic                 frame_start;
    logic                 frame_done;
    logic [DATA_BITS-1:0] pixel_out;
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic [7:0]           missed_frames;

    modport master (
        output fb_rd_addr,
        input  fb_rd_data,
        output display_buf,
        output render_buf,
        output frame_start,
        input  frame_done,
        output pixel_out,
        output hsync,
        output vsync,
        output de,
        output missed_frames
    );

    modport slave (
        input  fb_rd_addr,
        output fb_rd_data,
        input  display_buf,
        input  render_buf,
        input  frame_start,
        output frame_done,
        input  pixel_out,
        input  hsync,
        input  vsync,
        input  de,
        input  missed_frames
    );
endinterface

// File: rtl/framebuffer_scanout.sv
// ----------------------------------------------------------------------------
// framebuffer_scanout
//
// Streams a double-buffered framebuffer to a raster display. Each framebuffer
// pixel is replicated SCALE times horizontally and vertically. The block also
// owns buffer selection and the frame handshake with the renderer: it pulses
// frame_start at vblank and only swaps buffers once the renderer has signalled
// frame_done (rising edge) for the frame in flight.
//
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous reset, active low
//   bus  - framebuffer_scanout_if.master
//            fb_rd_addr/fb_rd_data : RAM read port, data 1 clk after address
//            display_buf/render_buf: buffer being scanned / being rendered
//            frame_start           : 1-clk pulse, a new frame may be rendered
//            frame_done            : renderer finished level (edge-detected)
//            pixel_out/hsync/vsync/de : video, all 2 clk behind the counters
//            missed_frames         : saturating count of vblanks while busy
// ----------------------------------------------------------------------------
module framebuffer_scanout #(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int SCALE                 = 4,
    parameter int H_ACTIVE              = 640,
    parameter int H_FP                  = 16,
    parameter int H_SYNC                = 96,
    parameter int H_BP                  = 48,
    parameter int V_ACTIVE              = 480,
    parameter int V_FP                  = 10,
    parameter int V_SYNC                = 2,
    parameter int V_BP                  = 33,
    parameter bit SYNC_ACTIVE_LOW       = 1'b1,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    framebuffer_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int AW      = FRAMEBUFFER_ADDR_BITS;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_IMG        = HW'(DISPLAY_WIDTH * SCALE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_IMG        = VW'(DISPLAY_HEIGHT * SCALE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] S_LAST       = SW'(SCALE - 1);
    localparam logic [AW-1:0] ROW_STEP     = AW'(DISPLAY_WIDTH);
    localparam logic          SYNC_IDLE    = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ---------------- raster and address counters ----------------
    // sx/x and sy/row_base track (h, v) so that no division is needed:
    // x = h / SCALE and row_base = (v / SCALE) * DISPLAY_WIDTH.
    logic [HW-1:0] h_reg, x_reg;
    logic [VW-1:0] v_reg;
    logic [SW-1:0] sx_reg, sy_reg;
    logic [AW-1:0] row_base_reg;   // may wrap below the image; only used inside it

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_reg        <= '0;
            v_reg        <= '0;
            sx_reg       <= '0;
            x_reg        <= '0;
            sy_reg       <= '0;
            row_base_reg <= '0;
        end else if (h_reg == H_LAST) begin
            h_reg  <= '0;
            sx_reg <= '0;
            x_reg  <= '0;
            if (v_reg == V_LAST) begin
                v_reg        <= '0;
                sy_reg       <= '0;
                row_base_reg <= '0;
            end else begin
                v_reg <= v_reg + 1'b1;
                if (sy_reg == S_LAST) begin
                    sy_reg       <= '0;
                    row_base_reg <= row_base_reg + ROW_STEP;
                end else begin
                    sy_reg <= sy_reg + 1'b1;
                end
            end
        end else begin
            h_reg <= h_reg + 1'b1;
            if (sx_reg == S_LAST) begin
                sx_reg <= '0;
                x_reg  <= x_reg + 1'b1;
            end else begin
                sx_reg <= sx_reg + 1'b1;
            end
        end
    end

    logic in_img, de_now, hs_now, vs_now, vblank;
    assign in_img = (h_reg < H_IMG) && (v_reg < V_IMG);
    assign de_now = (h_reg < H_ACT) && (v_reg < V_ACT);
    assign hs_now = ((h_reg >= H_SYNC_START) && (h_reg < H_SYNC_END)) ^ SYNC_IDLE;
    assign vs_now = ((v_reg >= V_SYNC_START) && (v_reg < V_SYNC_END)) ^ SYNC_IDLE;
    assign vblank = (h_reg == '0) && (v_reg == V_ACT);

    // ---------------- address register and 2-stage alignment ----------------
    // Stage 1: address register. Stage 2: RAM latency. Outside the image the
    // address is parked at 0 so the RAM is never read out of range.
    logic [AW-1:0] addr_reg;
    logic [1:0]    img_d_reg, de_d_reg, hs_d_reg, vs_d_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg  <= '0;
            img_d_reg <= '0;
            de_d_reg  <= '0;
            hs_d_reg  <= {2{SYNC_IDLE}};
            vs_d_reg  <= {2{SYNC_IDLE}};
        end else begin
            addr_reg  <= in_img ? (row_base_reg + AW'(x_reg)) : '0;
            img_d_reg <= {img_d_reg[0], in_img};
            de_d_reg  <= {de_d_reg[0], de_now};
            hs_d_reg  <= {hs_d_reg[0], hs_now};
            vs_d_reg  <= {vs_d_reg[0], vs_now};
        end
    end

    assign bus.fb_rd_addr = addr_reg;
    assign bus.pixel_out  = img_d_reg[1] ? bus.fb_rd_data : '0;
    assign bus.de         = de_d_reg[1];
    assign bus.hsync      = hs_d_reg[1];
    assign bus.vsync      = vs_d_reg[1];

    // ---------------- render handshake FSM ----------------
    // fd_prev resets to 1 so a frame_done level already high at release
    // is not mistaken for a completion.
    logic [1:0] state_reg;
    logic       fd_prev_reg, fd_rise;
    logic       display_buf_reg, frame_start_reg;
    logic [7:0] missed_reg;

    assign fd_rise = bus.frame_done & ~fd_prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            fd_prev_reg     <= 1'b1;
            display_buf_reg <= 1'b0;
            frame_start_reg <= 1'b0;
            missed_reg      <= '0;
        end else begin
            fd_prev_reg     <= bus.frame_done;
            frame_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (vblank) begin
                        frame_start_reg <= 1'b1;
                        state_reg       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A completion coinciding with vblank wins: no miss is
                    // counted and the swap waits for the next vblank.
                    if (fd_rise) begin
                        state_reg <= ST_DONE;
                    end else if (vblank && (missed_reg != 8'hFF)) begin
                        missed_reg <= missed_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (vblank) begin
                        display_buf_reg <= ~display_buf_reg;
                        frame_start_reg <= 1'b1;
                        state_reg       <= ST_BUSY;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.display_buf   = display_buf_reg;
    assign bus.render_buf    = ~display_buf_reg;
    assign bus.frame_start   = frame_start_reg;
    assign bus.missed_frames = missed_reg;
endmodule
